// File: rtl/snake_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : snake_frame_reader
//  Purpose  : Per game tick, erases the previous tail pixel, then walks the
//             snake ring buffer head->tail and emits one VGA plot per entry.
//  Options  : RENDER_FOOD_BLINK_EN - food entries blink on alternate frames.
//  Revision : 1.0 - initial release
// ============================================================================
module snake_frame_reader #(
    parameter int         ADDR_W      = 11,
    parameter logic [2:0] HEAD_COLOUR = 3'b010,
    parameter logic [2:0] BODY_COLOUR = 3'b011,
    parameter logic [2:0] FOOD_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] head_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [16:0]       rd_q,
    output logic [7:0]        x_out,
    output logic [6:0]        y_out,
    output logic [2:0]        colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ERASE  = 3'd1,
        READ   = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_idx;
    logic              r_drain_cnt;
    logic              r_q_valid;
    logic              r_q_last;
    logic              r_tail_valid;
    logic [7:0]        r_tail_x;
    logic [6:0]        r_tail_y;

    logic              w_accept;
    logic              w_is_last;
    logic [1:0]        w_type;
    logic [2:0]        w_food_colour;
    logic [2:0]        w_entry_colour;

    // A start coinciding with the done pulse belongs to the finished frame.
    assign w_accept  = (r_state == IDLE) && start && !done;
    assign w_is_last = (r_idx == (r_len - c_one));
    assign w_type    = rd_q[16:15];

`ifdef RENDER_FOOD_BLINK_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_parity <= 1'b0;
        else if (w_accept)
            r_parity <= ~r_parity;
    end

    assign w_food_colour = r_parity ? BG_COLOUR : FOOD_COLOUR;
`else
    assign w_food_colour = FOOD_COLOUR;
`endif

    always_comb begin
        w_entry_colour = BODY_COLOUR;
        case (w_type)
            2'b01:   w_entry_colour = HEAD_COLOUR;
            2'b11:   w_entry_colour = w_food_colour;
            default: w_entry_colour = BODY_COLOUR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_head       <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_drain_cnt  <= 1'b0;
            r_q_valid    <= 1'b0;
            r_q_last     <= 1'b0;
            r_tail_valid <= 1'b0;
            r_tail_x     <= '0;
            r_tail_y     <= '0;
            rd_addr      <= '0;
            rd_en        <= 1'b0;
            x_out        <= '0;
            y_out        <= '0;
            colour       <= '0;
            plot         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            plot      <= 1'b0;
            done      <= 1'b0;
            r_q_valid <= rd_en;
            r_q_last  <= rd_en && w_is_last;

            // Read data stage: rd_q holds the entry addressed last cycle.
            if (r_q_valid && (w_type != 2'b00)) begin
                plot   <= 1'b1;
                x_out  <= rd_q[14:7];
                y_out  <= rd_q[6:0];
                colour <= w_entry_colour;
                if (r_q_last) begin
                    r_tail_valid <= 1'b1;
                    r_tail_x     <= rd_q[14:7];
                    r_tail_y     <= rd_q[6:0];
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_head <= head_addr;
                        r_len  <= length;
                        r_idx  <= '0;
                        busy   <= 1'b1;
                        if (r_tail_valid) begin
                            plot    <= 1'b1;
                            colour  <= BG_COLOUR;
                            x_out   <= r_tail_x;
                            y_out   <= r_tail_y;
                            r_state <= ERASE;
                        end else if (length == '0) begin
                            r_state <= FINISH;
                        end else begin
                            rd_addr <= head_addr;
                            rd_en   <= 1'b1;
                            r_state <= READ;
                        end
                    end
                end
                ERASE: begin
                    if (r_len == '0) begin
                        r_state <= FINISH;
                    end else begin
                        rd_addr <= r_head;
                        rd_en   <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: begin
                    if (w_is_last) begin
                        rd_en       <= 1'b0;
                        r_drain_cnt <= 1'b0;
                        r_state     <= DRAIN;
                    end else begin
                        r_idx   <= r_idx + c_one;
                        rd_addr <= r_head - (r_idx + c_one);
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt)
                        r_state <= FINISH;
                    else
                        r_drain_cnt <= 1'b1;
                end
                FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
